rom_stream_reader: RTL and testbench

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

---
 rtl/rom_stream_pkg.sv | 15 +
 rtl/rom_stream_fifo.sv | 68 ++++++
 rtl/rom_stream_reader.sv | 194 +++++++++++++++++++
 tb/tb_rom_stream_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_stream_pkg.sv
// Shared types and default sizing for the ROM stream reader.
package rom_stream_pkg;

  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_MAX_DEPTH  = 2560;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rom_stream_fifo.sv
// Small synchronous FIFO buffering stream words (data plus sop/eop flags).
// DEPTH must be a power of two so the pointers wrap naturally.
module rom_stream_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] storage_q [DEPTH];
  logic [WIDTH-1:0] storage_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = storage_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  // Compute the next pointers, occupancy and storage contents.
  always_comb begin
    storage_d = storage_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    if (do_wr) begin
      storage_d[wr_ptr_q] = wr_data;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array holds data only, so it needs no reset.
  always_ff @(posedge clk) begin
    storage_q <= storage_d;
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Streams a block of words out of a 1-cycle-latency ROM onto a valid/ready
// stream. Reads are throttled so every returning word always has a FIFO slot;
// when the FIFO is empty the returning word is offered straight to the stream.
// Optional feature: define ROM_STREAM_CHECKSUM_EN to add a running checksum port.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MAX_DEPTH  = DEF_MAX_DEPTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_chipselect,
  output logic              m_clken,
  output logic [3:0]        m_byteenable,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
`ifdef ROM_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FIFO_W = DATA_W + 2;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   left_q, left_d;
  logic              first_q, first_d;
  logic              pend_q, pend_d;
  logic              pend_sop_q, pend_sop_d;
  logic              pend_eop_q, pend_eop_d;
  logic              zdone_q, zdone_d;

  logic [FIFO_W-1:0] fifo_wr_data, fifo_rd_data, head;
  logic              fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              issue, fire, bypass;
  logic [ADDR_W-1:0] start_addr;

`ifdef ROM_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d, checksum_now;
`endif

  assign start_addr   = ADDR_W'(32'(base_addr) % 32'(MAX_DEPTH));
  assign occupancy    = {1'b0, fifo_count} + (CNT_W+1)'(pend_q);
  assign issue        = (state_q == ST_READ) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign st_valid     = ~fifo_empty | pend_q;
  assign fire         = st_valid & st_ready;
  assign bypass       = fire & fifo_empty;
  assign fifo_rd_en   = fire & ~fifo_empty;
  assign fifo_wr_en   = pend_q & ~bypass;
  assign fifo_wr_data = {pend_sop_q, pend_eop_q, m_readdata};

  assign st_sop       = head[FIFO_W-1];
  assign st_eop       = head[FIFO_W-2];
  assign st_data      = head[DATA_W-1:0];
  assign done         = zdone_q | (fire & st_eop);
  assign busy         = (state_q != ST_IDLE);
  assign m_address    = addr_q;
  assign m_chipselect = issue;
  assign m_clken      = 1'b1;
  assign m_byteenable = 4'hF;
  assign m_write      = 1'b0;

  rom_stream_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Present the oldest word: FIFO head first, else the word landing this cycle.
  always_comb begin
    head = '0;
    if (!fifo_empty) begin
      head = fifo_rd_data;
    end else if (pend_q) begin
      head = fifo_wr_data;
    end
  end

  // Next-state logic: transfer sequencing, address walk and landing tags.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    left_d     = left_q;
    first_d    = first_q;
    zdone_d    = 1'b0;
    pend_d     = issue;
    pend_sop_d = issue & first_q;
    pend_eop_d = issue & (left_q == (ADDR_W+1)'(1));
`ifdef ROM_STREAM_CHECKSUM_EN
    checksum_now = checksum_q + (fire ? st_data : '0);
    checksum_d   = checksum_now;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef ROM_STREAM_CHECKSUM_EN
          checksum_d = '0;
`endif
          if (length == '0) begin
            zdone_d = 1'b1;
          end else begin
            state_d = ST_READ;
            addr_d  = start_addr;
            left_d  = length;
            first_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d  = (addr_q == ADDR_W'(MAX_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
          left_d  = left_q - (ADDR_W+1)'(1);
          first_d = 1'b0;
          if (left_q == (ADDR_W+1)'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fire && st_eop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any transfer and drops an in-flight return.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      first_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_sop_q <= 1'b0;
      pend_eop_q <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      first_q    <= first_d;
      pend_q     <= pend_d;
      pend_sop_q <= pend_sop_d;
      pend_eop_q <= pend_eop_d;
      zdone_q    <= zdone_d;
    end
  end

`ifdef ROM_STREAM_CHECKSUM_EN
  assign checksum = checksum_now;

  // Running sum of transferred words, cleared by reset and by a new start.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end
`endif

  // The read throttle must guarantee a landing word never meets a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(fifo_wr_en && fifo_full));

endmodule

// File: tb/tb_rom_stream_reader.sv
// Self-checking bench for rom_stream_reader: table-driven transfers, random
// transfers and hand-written reset / start-while-busy sequences, all checked
// against a queue-based model of the expected address and word streams.
// Optional feature: ROM_STREAM_CHECKSUM_EN enables the checksum checks.
module tb_rom_stream_reader;
  import rom_stream_pkg::*;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int MAX_DEPTH  = 2560;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   length = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect, m_clken, m_write;
  logic [3:0]        m_byteenable;
  logic [DATA_W-1:0] m_readdata = '0;
  logic [DATA_W-1:0] st_data;
  logic              st_valid, st_sop, st_eop;
  logic              st_ready = 1'b1;
`ifdef ROM_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  rom_stream_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_DEPTH  (MAX_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_clken      (m_clken),
    .m_byteenable (m_byteenable),
    .m_write      (m_write),
    .m_readdata   (m_readdata),
    .st_data      (st_data),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_sop       (st_sop),
    .st_eop       (st_eop)
`ifdef ROM_STREAM_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  // ROM model: data appears one cycle after the read strobe.
  logic [DATA_W-1:0] mem [MAX_DEPTH];
  always @(posedge clk) begin
    if (m_chipselect) begin
      m_readdata <= (int'(m_address) < MAX_DEPTH) ? mem[m_address] : 32'hDEADBEEF;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                sop;
    bit                eop;
  } word_t;

  typedef struct {
    int base;
    int len;
    bit rnd_ready;
    int exp_done_lat;
    int exp_first_lat;
  } vec_t;

  word_t             exp_words[$];
  int                exp_addrs[$];
  int                compared = 0;
  int                mismatched = 0;
  bit                mon_en = 1'b0;
  int                issued, xferred, done_seen, done_cyc, first_valid_cyc;
  logic [DATA_W-1:0] model_sum;
  bit                prev_stall;
  logic [DATA_W+1:0] prev_word;
  word_t             mon_w;
  int                mon_a;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every read strobe and every stream transfer against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        checkOutput("hold_valid", st_valid, 1);
        checkOutput("hold_word", {st_sop, st_eop, st_data}, prev_word);
      end
      if (st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_chipselect) begin
        if (exp_addrs.size() == 0) checkOutput("spurious_read", m_chipselect, 0);
        else begin
          mon_a = exp_addrs.pop_front();
          checkOutput("read_addr", m_address, mon_a);
        end
        checkOutput("occ_plus_inflight_below_depth", (issued - xferred) < FIFO_DEPTH, 1);
        issued++;
      end
      if (st_valid && st_ready) begin
        if (exp_words.size() == 0) checkOutput("spurious_word", st_valid, 0);
        else begin
          mon_w = exp_words.pop_front();
          checkOutput("st_data", st_data, mon_w.data);
          checkOutput("st_sop", st_sop, mon_w.sop);
          checkOutput("st_eop", st_eop, mon_w.eop);
          model_sum += mon_w.data;
        end
        xferred++;
      end
      if (done) begin
        done_seen++;
        done_cyc = cyc;
`ifdef ROM_STREAM_CHECKSUM_EN
        checkOutput("checksum_at_done", checksum, model_sum);
`endif
      end
      prev_stall = st_valid && !st_ready;
      prev_word  = {st_sop, st_eop, st_data};
    end
  end

  // Runs one transfer, building the expected streams from the memory contents.
  task automatic applyStimulus(input int base, input int len, input bit rnd_ready, input bit extra_start,
                               output int done_lat, output int first_lat, output int n_done, output int n_reads);
    int t0;
    int bound;
    exp_words.delete();
    exp_addrs.delete();
    issued = 0; xferred = 0; done_seen = 0; done_cyc = -1; first_valid_cyc = -1;
    model_sum = '0; prev_stall = 1'b0;
    for (int i = 0; i < len; i++) begin
      int a;
      a = (base + i) % MAX_DEPTH;
      exp_addrs.push_back(a);
      exp_words.push_back('{mem[a], (i == 0), (i == len - 1)});
    end
    mon_en = 1'b1;
    @(posedge clk); #2;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    length    = (ADDR_W+1)'(len);
    st_ready  = rnd_ready ? 1'($urandom % 2) : 1'b1;
    t0        = cyc;
    bound     = 20 * len + 20;
    for (int k = 0; k < bound && done_seen == 0; k++) begin
      @(posedge clk); #2;
      base_addr = ADDR_W'($urandom);
      length    = (ADDR_W+1)'($urandom_range(1, 30));
      start     = (extra_start && k == 3) ? 1'b1 : 1'b0;
      st_ready  = rnd_ready ? 1'($urandom % 2) : 1'b1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("words_left", exp_words.size(), 0);
    checkOutput("reads_left", exp_addrs.size(), 0);
    checkOutput("busy_after", busy, 0);
    checkOutput("valid_after", st_valid, 0);
    done_lat  = (done_cyc < 0) ? -1 : done_cyc - t0;
    first_lat = (first_valid_cyc < 0) ? -1 : first_valid_cyc - t0;
    n_done    = done_seen;
    n_reads   = issued;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[7];
    int done_lat, first_lat, n_done, n_reads;

    for (int i = 0; i < MAX_DEPTH; i++) mem[i] = DATA_W'(i);
    vecs[0] = '{0,    4,  1'b0, 5,  2};
    vecs[1] = '{2558, 4,  1'b0, 5,  2};
    vecs[2] = '{0,    16, 1'b1, -1, 2};
    vecs[3] = '{50,   0,  1'b0, 1,  -1};
    vecs[4] = '{7,    1,  1'b0, 2,  2};
    vecs[5] = '{4000, 6,  1'b0, 7,  2};
    vecs[6] = '{2550, 20, 1'b1, -1, 2};

    // Reset values.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_chipselect", m_chipselect, 0);
    checkOutput("rst_address", m_address, 0);
    checkOutput("rst_valid", st_valid, 0);
    checkOutput("rst_sop", st_sop, 0);
    checkOutput("rst_eop", st_eop, 0);
    checkOutput("rst_data", st_data, 0);
    checkOutput("const_outputs", {m_clken, m_byteenable, m_write}, 6'b1_1111_0);
    reset = 1'b0;

    foreach (vecs[v]) begin
      applyStimulus(vecs[v].base, vecs[v].len, vecs[v].rnd_ready, 1'b0, done_lat, first_lat, n_done, n_reads);
      checkOutput("done_count", n_done, 1);
      checkOutput("read_count", n_reads, vecs[v].len);
      checkOutput("first_valid_latency", first_lat, vecs[v].exp_first_lat);
      if (vecs[v].exp_done_lat >= 0) checkOutput("done_latency", done_lat, vecs[v].exp_done_lat);
    end

    // Start pulsed while busy must not disturb the running transfer.
    applyStimulus(100, 12, 1'b0, 1'b1, done_lat, first_lat, n_done, n_reads);
    checkOutput("busy_start_done_count", n_done, 1);
    checkOutput("busy_start_read_count", n_reads, 12);

    // Reset in the middle of a 10-word transfer.
    exp_words.delete(); exp_addrs.delete();
    issued = 0; xferred = 0; done_seen = 0; first_valid_cyc = -1; prev_stall = 1'b0; model_sum = '0;
    for (int i = 0; i < 10; i++) begin
      exp_addrs.push_back(300 + i);
      exp_words.push_back('{mem[300 + i], (i == 0), (i == 9)});
    end
    mon_en = 1'b1;
    @(posedge clk); #2;
    start = 1'b1; base_addr = ADDR_W'(300); length = (ADDR_W+1)'(10); st_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int k = 0; k < 40 && xferred < 5; k++) begin
      @(posedge clk); #2;
    end
    checkOutput("reached_word5", xferred, 5);
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_chipselect", m_chipselect, 0);
    checkOutput("mid_rst_address", m_address, 0);
    checkOutput("mid_rst_valid", st_valid, 0);
    checkOutput("mid_rst_sop_eop", {st_sop, st_eop}, 0);
    checkOutput("mid_rst_data", st_data, 0);
`ifdef ROM_STREAM_CHECKSUM_EN
    checkOutput("mid_rst_checksum", checksum, 0);
`endif
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      checkOutput("post_rst_valid", st_valid, 0);
      checkOutput("post_rst_chipselect", m_chipselect, 0);
    end
    applyStimulus(5, 8, 1'b0, 1'b0, done_lat, first_lat, n_done, n_reads);
    checkOutput("restart_done_count", n_done, 1);
    checkOutput("restart_done_latency", done_lat, 9);

`ifdef ROM_STREAM_CHECKSUM_EN
    mem[10] = 32'h1; mem[11] = 32'hFFFFFFFF; mem[12] = 32'h2;
    applyStimulus(10, 3, 1'b0, 1'b0, done_lat, first_lat, n_done, n_reads);
    checkOutput("checksum_final", checksum, 32'h2);
`endif

    // Random memory contents, bases and ready patterns.
    for (int i = 0; i < MAX_DEPTH; i++) mem[i] = $urandom;
    for (int r = 0; r < 8; r++) begin
      int rb, rl;
      rb = $urandom % 4096;
      rl = $urandom_range(1, 40);
      applyStimulus(rb, rl, 1'b1, 1'b0, done_lat, first_lat, n_done, n_reads);
      checkOutput("rand_done_count", n_done, 1);
      checkOutput("rand_read_count", n_reads, rl);
      checkOutput("rand_first_valid_latency", first_lat, 2);
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
